// File: rtl/door_sequencer.sv
// Motorised door sequencer: synchronises and debounces the operator button and
// drives the open/close motor through a Moore FSM with limit, obstruction and timeout handling.
module door_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TRAVEL_MAX      = 16,
    parameter int HOLD_CYCLES     = 32,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    input  logic limit_open,
    input  logic limit_closed,
    input  logic obstruct,
    output logic motor_open,
    output logic motor_close,
    output logic door_open,
    output logic fault
);

    localparam logic [2:0] S_CLOSED  = 3'd0;
    localparam logic [2:0] S_OPENING = 3'd1;
    localparam logic [2:0] S_OPEN    = 3'd2;
    localparam logic [2:0] S_CLOSING = 3'd3;
    localparam logic [2:0] S_FAULT   = 3'd4;

    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_MAX - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic             sync1_q, sync2_q;
    logic             db_level_q, db_level_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             press_q, press_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] travel_q, travel_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             travel_timeout;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        press_d    = 1'b0;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = ~db_level_q;
                press_d    = ~db_level_q;
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end
    end

    assign travel_timeout = (travel_q == TRAVEL_LAST);

    always_comb begin
        state_d = state_q;
        if (state_q != S_FAULT && limit_open && limit_closed) begin
            state_d = S_FAULT;
        end else begin
            case (state_q)
                S_CLOSED: if (press_q) state_d = S_OPENING;
                S_OPENING: begin
                    if (limit_open)          state_d = S_OPEN;
                    else if (press_q)        state_d = S_CLOSING;
                    else if (travel_timeout) state_d = S_FAULT;
                end
                S_OPEN: begin
                    if (press_q)                           state_d = S_CLOSING;
                    else if (!obstruct && hold_q == HOLD_LAST) state_d = S_CLOSING;
                end
                S_CLOSING: begin
                    if (limit_closed)              state_d = S_CLOSED;
                    else if (obstruct || press_q)  state_d = S_OPENING;
                    else if (travel_timeout)       state_d = S_FAULT;
                end
                default: state_d = S_FAULT;
            endcase
        end
    end

    // Any state change restarts both timers, which covers reversals as well as fresh entries.
    always_comb begin
        travel_d = travel_q;
        hold_d   = hold_q;
        if (state_d != state_q) begin
            travel_d = '0;
            hold_d   = '0;
        end else begin
            if ((state_q == S_OPENING || state_q == S_CLOSING) && travel_q != CNT_MAX)
                travel_d = travel_q + CNT_W'(1);
            if (state_q == S_OPEN) begin
                if (obstruct)              hold_d = '0;
                else if (hold_q != CNT_MAX) hold_d = hold_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
            press_q    <= 1'b0;
            state_q    <= S_CLOSED;
            travel_q   <= '0;
            hold_q     <= '0;
        end else begin
            sync1_q    <= button;
            sync2_q    <= sync1_q;
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            press_q    <= press_d;
            state_q    <= state_d;
            travel_q   <= travel_d;
            hold_q     <= hold_d;
        end
    end

    assign motor_open  = (state_q == S_OPENING);
    assign motor_close = (state_q == S_CLOSING);
    assign door_open   = (state_q == S_OPEN);
    assign fault       = (state_q == S_FAULT);

endmodule

// File: tb/tb_door_sequencer.sv
// Bench for door_sequencer: directed scenarios plus randomized traffic, all cycles
// compared against a timestamp-based behavioural model of the door.
module tb_door_sequencer;

    localparam int DB     = 4;
    localparam int TRAVEL = 16;
    localparam int HOLD   = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic button = 1'b0, limit_open = 1'b0, limit_closed = 1'b0, obstruct = 1'b0;
    logic motor_open, motor_close, door_open, fault;
    logic [3:0] outs;

    int n_tests = 0;
    int n_fail  = 0;

    door_sequencer #(
        .DEBOUNCE_CYCLES(DB), .TRAVEL_MAX(TRAVEL), .HOLD_CYCLES(HOLD), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .button(button),
        .limit_open(limit_open), .limit_closed(limit_closed), .obstruct(obstruct),
        .motor_open(motor_open), .motor_close(motor_close),
        .door_open(door_open), .fault(fault)
    );

    assign outs = {motor_open, motor_close, door_open, fault};

    always #5 clk = ~clk;

    // Reference model: door mode plus edge timestamps instead of counters.
    typedef enum int {M_CLOSED, M_OPENING, M_OPEN, M_CLOSING, M_FAULT} mode_t;
    mode_t m_mode;
    bit    hist[$];
    bit    m_level, m_press;
    int    t_now, t_entry, t_hold;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_outs();
        return {m_mode == M_OPENING, m_mode == M_CLOSING, m_mode == M_OPEN, m_mode == M_FAULT};
    endfunction

    task automatic model_reset();
        hist = {};
        repeat (DB + 2) hist.push_front(1'b0);
        m_level = 1'b0;
        m_press = 1'b0;
        m_mode  = M_CLOSED;
        t_now   = 0;
        t_entry = 0;
        t_hold  = 0;
    endtask

    task automatic model_step(input bit b, input bit lo, input bit lc, input bit ob);
        bit    press_now;
        bit    all_diff;
        mode_t nxt;
        press_now = m_press;
        t_now++;
        hist.push_front(b);
        if (hist.size() > DB + 2) void'(hist.pop_back());
        // level flips once the last DB synchronised samples all disagree with it
        all_diff = 1'b1;
        for (int k = 2; k <= DB + 1; k++) if (hist[k] == m_level) all_diff = 1'b0;
        m_press = 1'b0;
        if (all_diff) begin
            m_level = ~m_level;
            m_press = m_level;
        end
        nxt = m_mode;
        if (m_mode != M_FAULT && lo && lc) nxt = M_FAULT;
        else case (m_mode)
            M_CLOSED:  if (press_now) nxt = M_OPENING;
            M_OPENING: begin
                if (lo)                             nxt = M_OPEN;
                else if (press_now)                 nxt = M_CLOSING;
                else if (t_now - t_entry == TRAVEL) nxt = M_FAULT;
            end
            M_OPEN: begin
                if (press_now)                    nxt = M_CLOSING;
                else if (ob)                      t_hold = t_now;
                else if (t_now - t_hold == HOLD)  nxt = M_CLOSING;
            end
            M_CLOSING: begin
                if (lc)                             nxt = M_CLOSED;
                else if (ob || press_now)           nxt = M_OPENING;
                else if (t_now - t_entry == TRAVEL) nxt = M_FAULT;
            end
            default: ;
        endcase
        if (nxt != m_mode) begin
            t_entry = t_now;
            t_hold  = t_now;
        end
        m_mode = nxt;
    endtask

    task automatic cycle(input bit b, input bit lo, input bit lc, input bit ob);
        button = b; limit_open = lo; limit_closed = lc; obstruct = ob;
        @(posedge clk);
        model_step(b, lo, lc, ob);
        #1;
        check("outs_vs_model", {28'd0, outs}, {28'd0, m_outs()});
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_btn();
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(8);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        button = 1'b0; limit_open = 1'b0; limit_closed = 1'b0; obstruct = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_outs", {28'd0, outs}, 32'd0);
    endtask

    initial begin
        int rise;
        int rises;
        bit prev;
        bit b, lo, lc, ob;
        int blen;
        int r;

        // basic open/hold/close cycle
        do_reset();
        rise = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            if (motor_open && rise == 0) rise = i;
        end
        check("open_latency", rise - 1, 6);
        idle(5);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("door_open_after_limit", {31'd0, door_open}, 1);
        idle(31);
        check("still_open_at_31", {30'd0, motor_close, door_open}, 32'b01);
        idle(1);
        check("auto_close_at_32", {30'd0, motor_close, door_open}, 32'b10);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("closed_after_limit", {28'd0, outs}, 32'd0);

        // debounce: short glitch, then a long hold
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(20);
        check("glitch_no_press", {28'd0, outs}, 32'd0);
        rises = 0;
        prev  = motor_open;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, i == 12, 1'b0, 1'b0);
            if (motor_open && !prev) rises++;
            prev = motor_open;
        end
        check("hold_one_press", rises, 1);

        // obstruction during closing reverses, then travel timeout faults
        do_reset();
        press_btn();
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        press_btn();
        check("closing_before_obstruct", {31'd0, motor_close}, 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("reversal", {30'd0, motor_open, motor_close}, 32'b10);
        idle(15);
        check("no_fault_at_15", {31'd0, fault}, 0);
        idle(1);
        check("fault_at_16", {28'd0, outs}, 32'b0001);

        // hold restart by obstruct at hold count 30
        do_reset();
        press_btn();
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle(30);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        idle(31);
        check("hold_restarted", {31'd0, door_open}, 1);
        idle(1);
        check("close_32_after_obstruct", {31'd0, motor_close}, 1);

        // limit_closed beats a simultaneous press while closing
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("limit_beats_press", {28'd0, outs}, 32'd0);
        idle(8);

        // both limits in OPEN -> sticky fault
        press_btn();
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check("conflict_fault", {28'd0, outs}, 32'b0001);
        press_btn();
        press_btn();
        check("fault_sticky", {28'd0, outs}, 32'b0001);

        // asynchronous reset mid-opening
        do_reset();
        press_btn();
        check("opening_before_reset", {31'd0, motor_open}, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_drop", {31'd0, motor_open}, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_reset_outs", {28'd0, outs}, 32'd0);

        // randomized traffic
        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            blen = 0;
            b = 1'b0;
            for (int c = 0; c < 200; c++) begin
                if (blen == 0) begin
                    b    = 1'($urandom_range(0, 1));
                    blen = int'($urandom_range(1, 12));
                end
                blen--;
                r  = int'($urandom_range(0, 99));
                lo = (r < 4) || (r == 8);
                lc = (r >= 4 && r < 8) || (r == 8);
                ob = ($urandom_range(0, 19) == 0);
                cycle(b, lo, lc, ob);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
